// File: rtl/des_key_schedule.sv
// DES round-key generator: loads PC-1(key) into C/D on start, then walks the
// rotation schedule one step per accepted subkey. PC-2 is combinational from
// C/D so the presented subkey is always in step with the registers. Decrypt
// mode starts at C16/D16 (which equals C0/D0) and rotates right.
module des_key_schedule #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  // Tables hold FIPS 1-based bit numbers; FIPS bit 1 is the MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {StIdle, StActive} state_e;

  state_e      state_q;
  logic [27:0] c_q, d_q;
  logic        dec_q;
  logic [55:0] pc1_out;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic        xfer;
  logic        two;
  logic [3:0]  sched_idx;
  logic        unused_parity;

  // Parity bits (FIPS 8,16,...,64) take no part in the schedule.
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_out[55-i] = key[64-PC1[i]];
  end

  assign cd = {c_q, d_q};

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign pc2_out[47-i] = cd[56-PC2[i]];
  end

  // 28-bit circular rotate by 1 or 2, left or right.
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic by_two,
                                        input logic right);
    logic [27:0] r;
    if (right) r = by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    else       r = by_two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) shift by one; all others by two.
  function automatic logic shift_is_two(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  // Pick the shift for the step that follows the current delivery.
  always_comb begin
    sched_idx = dec_q ? (4'd15 - round) : (round + 4'd1);
    two       = shift_is_two(sched_idx);
  end

  assign xfer   = subkey_valid && subkey_ready;
  assign subkey = subkey_valid ? pc2_out : 48'h0;

  // Schedule FSM: load on start, advance C/D and round on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      c_q          <= '0;
      d_q          <= '0;
      dec_q        <= 1'b0;
      round        <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Encrypt presents K1, so pre-apply the first left shift.
            c_q          <= decrypt ? pc1_out[55:28] : rot28(pc1_out[55:28], 1'b0, 1'b0);
            d_q          <= decrypt ? pc1_out[27:0]  : rot28(pc1_out[27:0], 1'b0, 1'b0);
            dec_q        <= decrypt;
            round        <= '0;
            subkey_valid <= 1'b1;
            busy         <= 1'b1;
            state_q      <= StActive;
          end
        end
        StActive: begin
          if (xfer) begin
            if (round == 4'(ROUNDS - 1)) begin
              subkey_valid <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state_q      <= StIdle;
            end else begin
              c_q   <= rot28(c_q, two, dec_q);
              d_q   <= rot28(d_q, two, dec_q);
              round <= round + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: expected subkeys are queued when a schedule is
// started and consumed when the DUT hands a subkey over.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  r;
    logic [47:0] k;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] KeyStd = 64'h1334_5779_9BBC_DFF1;

  // Published K1..K16 for KeyStd.
  logic [47:0] ktab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is accepted at the next posedge.
  task automatic kick(input logic [63:0] k, input bit dec, input bit zero);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.r = 4'(i);
      e.k = zero ? 48'h0 : (dec ? ktab[15-i] : ktab[i]);
      sb.push_back(e);
    end
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    // Changing inputs after acceptance must not disturb the schedule.
    key     = ~k;
    decrypt = ~dec;
    chk("valid_after_start", subkey_valid, 1);
    chk("busy_after_start", busy, 1);
  endtask

  // Consume the queued subkeys. mode 1 adds random backpressure with 5-cycle
  // stalls; inject pulses start at that round; cut asserts reset at that round.
  task automatic drain(input int mode, input int inject, input int cut);
    int cyc = 0;
    while (sb.size() > 0 && cyc < 400) begin
      if (mode == 0) subkey_ready = 1'b1;
      else subkey_ready = ($urandom_range(0, 2) != 0) && !(cyc >= 6 && cyc < 11)
                          && !(cyc >= 25 && cyc < 30);
      start = (inject >= 0 && subkey_valid && round == 4'(inject));
      if (cut >= 0 && subkey_valid && round == 4'(cut)) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", subkey_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_subkey", subkey, 0);
        chk("rst_round", round, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        subkey_ready = 1'b0;
        return;
      end
      chk("valid_while_pending", subkey_valid, 1);
      chk("busy_while_pending", busy, 1);
      if (subkey_valid) begin
        chk("round", round, sb[0].r);
        chk("subkey", subkey, sb[0].k);
        if (subkey_ready) void'(sb.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (sb.size() > 0) begin
      chk("timeout", 0, 1);
      sb.delete();
    end
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", subkey_valid, 0);
    subkey_ready = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    key = '0;
    subkey_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", subkey_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_subkey", subkey, 0);
    chk("reset_round", round, 0);
    rst = 1'b0;
    @(negedge clk);

    // Encrypt, ready held high.
    kick(KeyStd, 1'b0, 1'b0);
    drain(0, -1, -1);
    idle_check();

    // Decrypt: reversed order.
    kick(KeyStd, 1'b1, 1'b0);
    drain(0, -1, -1);
    idle_check();

    // Backpressure.
    kick(KeyStd, 1'b0, 1'b0);
    drain(1, -1, -1);
    idle_check();

    // All-zero key and parity-only key.
    kick(64'h0, 1'b0, 1'b1);
    drain(0, -1, -1);
    idle_check();
    kick(64'h0101_0101_0101_0101, 1'b0, 1'b1);
    drain(0, -1, -1);
    idle_check();

    // Reset in round 7, then a clean restart.
    kick(KeyStd, 1'b0, 1'b0);
    drain(0, -1, 6);
    kick(KeyStd, 1'b0, 1'b0);
    drain(0, -1, -1);
    idle_check();

    // Start during ACTIVE is ignored; start in the done cycle chains directly.
    kick(KeyStd, 1'b0, 1'b0);
    drain(0, 3, -1);
    kick(KeyStd, 1'b1, 1'b0);
    drain(0, -1, -1);
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
